// File: rtl/traffic_input_conditioner_pkg.sv
// Shared constants for the traffic-light front end: system clock rate and
// default debounce window used by the conditioner and the divider.
package traffic_input_conditioner_pkg;

  localparam int unsigned CLOCK_HZ            = 32'd50_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 32'd500_000;
  localparam int unsigned CNT_W_DEF           = 32'd19;

endpackage : traffic_input_conditioner_pkg

// File: rtl/traffic_input_conditioner_debounce_channel.sv
// One conditioning channel: 2-flop synchroniser, debounce counter, registered
// stable level and a one-cycle pulse on each accepted 0->1 transition.
module debounce_channel
  import traffic_input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  logic             s1_r;
  logic             s2_r;
  logic             stable_r;
  logic             pulse_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchronise raw pin, then accept s2 only after it differs from stable for the full window.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_r     <= 1'b0;
      s2_r     <= 1'b0;
      stable_r <= 1'b0;
      pulse_r  <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      s1_r    <= raw;
      s2_r    <= s1_r;
      pulse_r <= 1'b0;
      if (s2_r == stable_r) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
        // Terminal compare keeps the counter from wrapping; pulse only on a rising acceptance.
        stable_r <= s2_r;
        pulse_r  <= s2_r;
        cnt_r    <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign level = stable_r;
  assign pulse = pulse_r;

endmodule : debounce_channel

// File: rtl/traffic_input_conditioner.sv
// Conditions the four raw button/sensor pins into clean levels and the walk
// request pulse; four independent debounce channels, wiring only.
module traffic_input_conditioner
  import traffic_input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic reset_btn,
  input  logic sensor_raw,
  input  logic walk_btn,
  input  logic prog_btn,
  output logic reset_sync,
  output logic sensor_sync,
  output logic prog_sync,
  output logic wr_sync
);

  logic walk_level_s;

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_reset_ch (
    .clock(clock), .reset_n(reset_n), .raw(reset_btn), .level(reset_sync), .pulse()
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_sensor_ch (
    .clock(clock), .reset_n(reset_n), .raw(sensor_raw), .level(sensor_sync), .pulse()
  );

  // Walk consumers only need the press event, so the level stays internal.
  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_walk_ch (
    .clock(clock), .reset_n(reset_n), .raw(walk_btn), .level(walk_level_s), .pulse(wr_sync)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_prog_ch (
    .clock(clock), .reset_n(reset_n), .raw(prog_btn), .level(prog_sync), .pulse()
  );

endmodule : traffic_input_conditioner
